alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

- Request-side front end for the combinational 8-bit ALU (add / sub-with-swap / mul / div-with-swap).
- Accepts operation requests over a valid/ready handshake and drives the ALU operand and code inputs from registers.
- Waits a programmable settle time, captures `result` and `swap`, and returns them over a valid/ready response channel.
- Rejects illegal codes and, optionally, zero-divisor divides without issuing them to the ALU.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles the ALU inputs are held before capture. Legal range 1–15.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `reqValid` in 1: request present.
- `reqReady` out 1: request accepted when high with `reqValid` at a rising edge.
- `reqA`, `reqB` in 8: unsigned operands.
- `reqCode` in 3: 000 add, 001 sub, 010 mul, 011 div; 100–111 illegal.
- `aluA`, `aluB` out 8: registered operands to the ALU.
- `aluCode` out 3: registered code to the ALU.
- `aluResult` in 8: ALU result.
- `aluSwap` in 1: ALU swap flag.
- `rspValid` out 1: response present.
- `rspReady` in 1: response consumed when high with `rspValid` at a rising edge.
- `rspResult` out 8: captured result.
- `rspSwap` out 1: captured swap flag.
- `rspErr` out 1: request was rejected and not issued.
- `rspCode` out 3: code of the request this response answers.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **FSM states: IDLE, SETTLE, RESP.**
- **IDLE**
  - `reqReady` = 1.
  - On accept of a legal, unguarded request: load `aluA`/`aluB`/`aluCode` from `reqA`/`reqB`/`reqCode`, load the settle counter with `SETTLE_CYCLES-1`, go to SETTLE.
  - On accept of an illegal or guarded request: `aluA`/`aluB`/`aluCode` keep their old values, the response registers are loaded directly, go to RESP.
- **SETTLE**
  - Counter decrements each cycle.
  - At the edge where the counter is 0: capture `aluResult` into `rspResult` and `aluSwap` into `rspSwap`, set `rspErr` = 0, go to RESP.
- **RESP**
  - `rspValid` = 1; all `rsp*` outputs stay stable until the handshake.
  - On `rspReady`: go to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- **Illegal code (100–111):** `rspResult` = 0x00, `rspSwap` = 0, `rspErr` = 1.
- `rspCode` always echoes the accepted `reqCode`.
- Results are the ALU's 8-bit truncated values. The sequencer does no arithmetic except the divisor check.
- `aluA`/`aluB`/`aluCode` hold the last issued values between operations, so the ALU inputs never glitch.

## Timing
- **Reset values:**
  - State IDLE.
  - `aluA`, `aluB` = 0x00; `aluCode` = 000.
  - `rspValid` = 0, `rspResult` = 0x00, `rspSwap` = 0, `rspErr` = 0, `rspCode` = 000.
  - `busy` = 0.
  - `reqReady` is forced 0 while `reset` is high.
- **Issued op accepted at edge T:**
  - ALU inputs are valid from T.
  - Capture happens at edge T+`SETTLE_CYCLES`.
  - `rspValid` is high from edge T+`SETTLE_CYCLES`.
- **Rejected op accepted at T:** `rspValid` is high from T (one-cycle turnaround).
- **Throughput:** best case one op per `SETTLE_CYCLES`+2 cycles (accept, settle, response handshake, return to IDLE).
- **Backpressure:** with `rspReady` low, the FSM stays in RESP indefinitely and `reqReady` stays 0.
- **Reset mid-operation:** any in-flight op is dropped. No response is produced, and `rspValid` is 0 at the first edge with `reset` high.

## Configuration
- Macro: `ALU_DIV0_GUARD_EN`.
- **Defined:** code 011 with min(`reqA`,`reqB`) == 0 (the ALU divisor is zero on either swap path) is rejected. Response is `rspResult` = 0xFF, `rspSwap` = (`reqA` < `reqB`), `rspErr` = 1, with the rejected-op timing.
- **Undefined:** zero-divisor divides are issued normally and `rspResult`/`rspSwap` are whatever the ALU produces. `rspErr` is set only for illegal codes.

## Test plan
The bench instantiates the combinational ALU model wired to the `alu*` ports and uses `SETTLE_CYCLES` = 1 unless stated.
- Add, A=200, B=100 -> `rspResult` 0x2C, `rspSwap` 0, `rspErr` 0; `rspValid` exactly 1 cycle after accept.
- Sub, A=5, B=9 -> `rspResult` 4, `rspSwap` 1. Mul, A=16, B=17 -> `rspResult` 0x10, `rspSwap` 0.
- Div, A=7, B=100 with `SETTLE_CYCLES`=4 -> `rspResult` 14, `rspSwap` 1; `rspValid` rises 4 cycles after accept; `busy` high throughout.
- Code 101, A=3, B=3 -> `rspErr` 1, `rspResult` 0x00, `rspValid` 0 cycles after accept; `aluCode` unchanged. With `ALU_DIV0_GUARD_EN`: div A=0, B=5 -> `rspErr` 1, `rspResult` 0xFF, `rspSwap` 1.
- Hold `rspReady` low 3 cycles on add 1+1 while `reqValid` stays high with new data -> `rspResult` holds 2, `reqReady` stays 0, and the next op is accepted only in the cycle after the response handshake.
- Assert `reset` in the SETTLE state of a `SETTLE_CYCLES`=4 op -> no response; all outputs at reset values; the next add 3+4 returns 7.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Bus bundle between a requester, the alu_op_sequencer and the combinational ALU.
// Carries the request channel, the registered ALU operand/code drive, the ALU
// result/swap return and the response channel. The slave modport is the
// sequencer's view; the master modport is the environment (requester + ALU).
interface alu_op_sequencer_if;
    // Request channel
    logic       reqValid;
    logic       reqReady;
    logic [7:0] reqA;
    logic [7:0] reqB;
    logic [2:0] reqCode;

    // ALU drive and return
    logic [7:0] aluA;
    logic [7:0] aluB;
    logic [2:0] aluCode;
    logic [7:0] aluResult;
    logic       aluSwap;

    // Response channel
    logic       rspValid;
    logic       rspReady;
    logic [7:0] rspResult;
    logic       rspSwap;
    logic       rspErr;
    logic [2:0] rspCode;

    // Status
    logic       busy;

    modport slave (
        input  reqValid, reqA, reqB, reqCode,
        input  aluResult, aluSwap,
        input  rspReady,
        output reqReady,
        output aluA, aluB, aluCode,
        output rspValid, rspResult, rspSwap, rspErr, rspCode,
        output busy
    );

    modport master (
        output reqValid, reqA, reqB, reqCode,
        output aluResult, aluSwap,
        output rspReady,
        input  reqReady,
        input  aluA, aluB, aluCode,
        input  rspValid, rspResult, rspSwap, rspErr, rspCode,
        input  busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: request-side front end for the combinational 8-bit ALU.
// Accepts an op, holds registered operands/code on the ALU for SETTLE_CYCLES,
// captures result/swap and returns them on a valid/ready response channel.
// Illegal codes (1xx) are answered directly without touching the ALU inputs.
// Optional feature macro: ALU_DIV0_GUARD_EN -- when defined, a divide whose
// divisor would be zero on either swap path is rejected instead of issued.
// Also contains alu_op_sequencer_chk, a port-level protocol checker.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    alu_op_sequencer_if.slave   io_bus
);

    // Out-of-range settings are clamped so the 4-bit counter always works.
    localparam int LP_SETTLE = (SETTLE_CYCLES < 1)  ? 1  :
                               (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
    localparam logic [3:0] LP_CNT_LOAD = 4'(LP_SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;

    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [2:0] r_alu_code;

    logic       r_rsp_valid;
    logic [7:0] r_rsp_result;
    logic       r_rsp_swap;
    logic       r_rsp_err;
    logic [2:0] r_rsp_code;
    logic       r_busy;

    logic       w_req_ready;
    logic       w_accept;
    logic       w_illegal;
    logic       w_guarded;
    logic       w_reject;
    logic       w_cnt_zero;
    logic [7:0] w_rej_result;
    logic       w_rej_swap;

    // Ready only in IDLE, and never while reset is held.
    assign w_req_ready = (r_state == IDLE) && !reset;
    assign w_accept    = w_req_ready && io_bus.reqValid;
    assign w_illegal   = io_bus.reqCode[2];
    assign w_cnt_zero  = (r_cnt == 4'd0);

`ifdef ALU_DIV0_GUARD_EN
    // The ALU divides the larger operand by the smaller, so a zero in either
    // operand means a zero divisor whichever way it swaps.
    assign w_guarded = (io_bus.reqCode == 3'b011) &&
                       ((io_bus.reqA == 8'h00) || (io_bus.reqB == 8'h00));
`else
    assign w_guarded = 1'b0;
`endif

    assign w_reject = w_illegal || w_guarded;

    // Response payload for a request answered without issuing it to the ALU.
    always_comb begin
        w_rej_result = 8'h00;
        w_rej_swap   = 1'b0;
        if (w_guarded) begin
            w_rej_result = 8'hFF;
            w_rej_swap   = (io_bus.reqA < io_bus.reqB);
        end else begin
            w_rej_result = 8'h00;
            w_rej_swap   = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_reject ? RESP : SETTLE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SETTLE: begin
                if (w_cnt_zero) begin
                    w_state_next = RESP;
                end else begin
                    w_state_next = SETTLE;
                end
            end
            RESP: begin
                if (io_bus.rspReady) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = RESP;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: ALU drive registers, settle counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_alu_a      <= 8'h00;
            r_alu_b      <= 8'h00;
            r_alu_code   <= 3'b000;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 8'h00;
            r_rsp_swap   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_code   <= 3'b000;
            r_busy       <= 1'b0;
        end else begin
            r_rsp_valid <= (w_state_next == RESP);
            r_busy      <= (w_state_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rsp_code <= io_bus.reqCode;
                        if (w_reject) begin
                            r_rsp_result <= w_rej_result;
                            r_rsp_swap   <= w_rej_swap;
                            r_rsp_err    <= 1'b1;
                        end else begin
                            r_alu_a    <= io_bus.reqA;
                            r_alu_b    <= io_bus.reqB;
                            r_alu_code <= io_bus.reqCode;
                            r_cnt      <= LP_CNT_LOAD;
                        end
                    end
                end
                SETTLE: begin
                    if (w_cnt_zero) begin
                        r_rsp_result <= io_bus.aluResult;
                        r_rsp_swap   <= io_bus.aluSwap;
                        r_rsp_err    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Response registers hold until the handshake.
                end
                default: begin
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign io_bus.reqReady  = w_req_ready;
    assign io_bus.aluA      = r_alu_a;
    assign io_bus.aluB      = r_alu_b;
    assign io_bus.aluCode   = r_alu_code;
    assign io_bus.rspValid  = r_rsp_valid;
    assign io_bus.rspResult = r_rsp_result;
    assign io_bus.rspSwap   = r_rsp_swap;
    assign io_bus.rspErr    = r_rsp_err;
    assign io_bus.rspCode   = r_rsp_code;
    assign io_bus.busy      = r_busy;

endmodule

// Port-level protocol checker for alu_op_sequencer.
module alu_op_sequencer_chk (
    input logic       i_clk,
    input logic       i_reset,
    input logic       i_req_ready,
    input logic       i_busy,
    input logic       i_rsp_valid,
    input logic       i_rsp_ready,
    input logic [7:0] i_rsp_result,
    input logic       i_rsp_swap,
    input logic       i_rsp_err,
    input logic [2:0] i_rsp_code
);
    // Ready is only offered when idle with no response pending.
    a_ready_idle: assert property (@(posedge i_clk)
        i_req_ready |-> (!i_busy && !i_rsp_valid));

    // A pending response implies the sequencer is busy.
    a_valid_busy: assert property (@(posedge i_clk)
        i_rsp_valid |-> i_busy);

    // A stalled response keeps its payload.
    a_rsp_stable: assert property (@(posedge i_clk) disable iff (i_reset)
        (i_rsp_valid && !i_rsp_ready) |=>
        (i_rsp_valid && $stable(i_rsp_result) && $stable(i_rsp_swap) &&
         $stable(i_rsp_err) && $stable(i_rsp_code)));

    // Reset clears the response and busy flags at the edge it is seen.
    a_reset_clear: assert property (@(posedge i_clk)
        i_reset |=> (!i_rsp_valid && !i_busy));
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: two instances (SETTLE_CYCLES 1 and
// 4) each driving a combinational ALU model; expected responses go through a
// scoreboard queue and are compared when the response appears.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic [7:0] res;
        logic       swp;
        logic       err;
        logic [2:0] code;
    } exp_t;

    logic clk;
    logic rst1, rst4;
    logic v1, v4;
    logic [7:0] tb_a, tb_b;
    logic [2:0] tb_code;
    logic tb_rsp_ready;
    bit   sel;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    alu_op_sequencer_if bus1 ();
    alu_op_sequencer_if bus4 ();

    // Combinational ALU model: {swap, result}
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] c);
        logic [7:0] r;
        logic       s;
        r = 8'h00;
        s = 1'b0;
        case (c)
            3'b000: r = a + b;
            3'b001: begin s = (a < b); r = s ? (b - a) : (a - b); end
            3'b010: r = a * b;
            3'b011: begin
                s = (a < b);
                if (s) r = (a == 8'h00) ? 8'hFF : (b / a);
                else   r = (b == 8'h00) ? 8'hFF : (a / b);
            end
            default: r = 8'h00;
        endcase
        return {s, r};
    endfunction

    // Expected sequencer response for a request
    function automatic exp_t exp_f(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] c);
        exp_t e;
        logic [8:0] sr;
        e.code = c;
        if (c[2]) begin
            e.res = 8'h00; e.swp = 1'b0; e.err = 1'b1;
`ifdef ALU_DIV0_GUARD_EN
        end else if (c == 3'b011 && (a == 8'h00 || b == 8'h00)) begin
            e.res = 8'hFF; e.swp = (a < b); e.err = 1'b1;
`endif
        end else begin
            sr = alu_f(a, b, c);
            e.res = sr[7:0]; e.swp = sr[8]; e.err = 1'b0;
        end
        return e;
    endfunction

    assign bus1.reqValid = v1;
    assign bus1.reqA     = tb_a;
    assign bus1.reqB     = tb_b;
    assign bus1.reqCode  = tb_code;
    assign bus1.rspReady = tb_rsp_ready;
    assign {bus1.aluSwap, bus1.aluResult} = alu_f(bus1.aluA, bus1.aluB, bus1.aluCode);

    assign bus4.reqValid = v4;
    assign bus4.reqA     = tb_a;
    assign bus4.reqB     = tb_b;
    assign bus4.reqCode  = tb_code;
    assign bus4.rspReady = tb_rsp_ready;
    assign {bus4.aluSwap, bus4.aluResult} = alu_f(bus4.aluA, bus4.aluB, bus4.aluCode);

    alu_op_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .reset(rst1), .io_bus(bus1));
    alu_op_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (.clk(clk), .reset(rst4), .io_bus(bus4));

    alu_op_sequencer_chk u_chk1 (
        .i_clk(clk), .i_reset(rst1), .i_req_ready(bus1.reqReady), .i_busy(bus1.busy),
        .i_rsp_valid(bus1.rspValid), .i_rsp_ready(bus1.rspReady),
        .i_rsp_result(bus1.rspResult), .i_rsp_swap(bus1.rspSwap),
        .i_rsp_err(bus1.rspErr), .i_rsp_code(bus1.rspCode));
    alu_op_sequencer_chk u_chk4 (
        .i_clk(clk), .i_reset(rst4), .i_req_ready(bus4.reqReady), .i_busy(bus4.busy),
        .i_rsp_valid(bus4.rspValid), .i_rsp_ready(bus4.rspReady),
        .i_rsp_result(bus4.rspResult), .i_rsp_swap(bus4.rspSwap),
        .i_rsp_err(bus4.rspErr), .i_rsp_code(bus4.rspCode));

    // Observation mux for the selected instance
    logic       m_req_ready, m_rsp_valid, m_busy, m_rsp_swap, m_rsp_err;
    logic [7:0] m_rsp_result, m_alu_a, m_alu_b;
    logic [2:0] m_rsp_code, m_alu_code;
    assign m_req_ready  = sel ? bus4.reqReady  : bus1.reqReady;
    assign m_rsp_valid  = sel ? bus4.rspValid  : bus1.rspValid;
    assign m_busy       = sel ? bus4.busy      : bus1.busy;
    assign m_rsp_result = sel ? bus4.rspResult : bus1.rspResult;
    assign m_rsp_swap   = sel ? bus4.rspSwap   : bus1.rspSwap;
    assign m_rsp_err    = sel ? bus4.rspErr    : bus1.rspErr;
    assign m_rsp_code   = sel ? bus4.rspCode   : bus1.rspCode;
    assign m_alu_a      = sel ? bus4.aluA      : bus1.aluA;
    assign m_alu_b      = sel ? bus4.aluB      : bus1.aluB;
    assign m_alu_code   = sel ? bus4.aluCode   : bus1.aluCode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input bit v);
        if (sel) v4 = v; else v1 = v;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rsp_valid"},  {31'b0, m_rsp_valid}, 32'd0);
        chk({tag, "_busy"},       {31'b0, m_busy}, 32'd0);
        chk({tag, "_alu_a"},      {24'b0, m_alu_a}, 32'd0);
        chk({tag, "_alu_b"},      {24'b0, m_alu_b}, 32'd0);
        chk({tag, "_alu_code"},   {29'b0, m_alu_code}, 32'd0);
        chk({tag, "_rsp_result"}, {24'b0, m_rsp_result}, 32'd0);
        chk({tag, "_rsp_swap"},   {31'b0, m_rsp_swap}, 32'd0);
        chk({tag, "_rsp_err"},    {31'b0, m_rsp_err}, 32'd0);
        chk({tag, "_rsp_code"},   {29'b0, m_rsp_code}, 32'd0);
    endtask

    // Present a request at a negedge and return just after its accepting edge.
    task automatic drive_accept(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
        int n;
        @(negedge clk);
        tb_a = a; tb_b = b; tb_code = c;
        set_valid(1'b1);
        n = 0;
        while (!m_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {31'b0, m_req_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Count cycles from the accepting edge until rspValid, checking busy meanwhile.
    task automatic wait_rsp(input int lat, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!m_rsp_valid && k < 40) begin
            chk({tag, "_busy_wait"}, {31'b0, m_busy}, 32'd1);
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, k, lat);
    endtask

    // Pop the scoreboard, compare the response, then complete the handshake.
    task automatic finish_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_result"}, {24'b0, m_rsp_result}, {24'b0, e.res});
            chk({tag, "_swap"},   {31'b0, m_rsp_swap},   {31'b0, e.swp});
            chk({tag, "_err"},    {31'b0, m_rsp_err},    {31'b0, e.err});
            chk({tag, "_code"},   {29'b0, m_rsp_code},   {29'b0, e.code});
        end
        chk({tag, "_busy_rsp"}, {31'b0, m_busy}, 32'd1);
        tb_rsp_ready = 1'b1;
        @(negedge clk);
        tb_rsp_ready = 1'b0;
        chk({tag, "_valid_after"}, {31'b0, m_rsp_valid}, 32'd0);
        chk({tag, "_busy_after"},  {31'b0, m_busy}, 32'd0);
        chk({tag, "_ready_after"}, {31'b0, m_req_ready}, 32'd1);
    endtask

    task automatic run_op(input bit s4, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] c, input logic [7:0] er, input logic es,
                          input logic ee, input int lat, input string tag);
        exp_t e;
        sel = s4;
        e.res = er; e.swp = es; e.err = ee; e.code = c;
        sb.push_back(e);
        drive_accept(a, b, c);
        set_valid(1'b0);
        wait_rsp(lat, tag);
        finish_rsp(tag);
    endtask

    initial begin
        exp_t e;
        logic [7:0] ra, rb;
        logic [2:0] rc;
        rst1 = 1'b1; rst4 = 1'b1;
        v1 = 1'b0; v4 = 1'b0;
        tb_a = 8'h00; tb_b = 8'h00; tb_code = 3'b000;
        tb_rsp_ready = 1'b0;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        check_reset_state("reset1");
        chk("reset1_ready", {31'b0, m_req_ready}, 32'd0);
        sel = 1'b1;
        check_reset_state("reset4");
        chk("reset4_ready", {31'b0, m_req_ready}, 32'd0);
        rst1 = 1'b0; rst4 = 1'b0;

        // Directed ops, SETTLE_CYCLES = 1
        run_op(1'b0, 8'd200, 8'd100, 3'b000, 8'h2C, 1'b0, 1'b0, 1, "add");
        run_op(1'b0, 8'd5,   8'd9,   3'b001, 8'd4,  1'b1, 1'b0, 1, "sub");
        run_op(1'b0, 8'd16,  8'd17,  3'b010, 8'h10, 1'b0, 1'b0, 1, "mul");
        run_op(1'b0, 8'd3,   8'd3,   3'b101, 8'h00, 1'b0, 1'b1, 0, "illegal");
        chk("illegal_alu_code", {29'b0, m_alu_code}, 32'd2);
        chk("illegal_alu_a",    {24'b0, m_alu_a}, 32'd16);
        chk("illegal_alu_b",    {24'b0, m_alu_b}, 32'd17);
`ifdef ALU_DIV0_GUARD_EN
        run_op(1'b0, 8'd0, 8'd5, 3'b011, 8'hFF, 1'b1, 1'b1, 0, "div0_guard");
        chk("div0_alu_code", {29'b0, m_alu_code}, 32'd2);
`else
        run_op(1'b0, 8'd0, 8'd5, 3'b011, 8'hFF, 1'b1, 1'b0, 1, "div0_issue");
        chk("div0_alu_code", {29'b0, m_alu_code}, 32'd3);
`endif

        // Divide with SETTLE_CYCLES = 4
        run_op(1'b1, 8'd7, 8'd100, 3'b011, 8'd14, 1'b1, 1'b0, 4, "div4");

        // Backpressure: response held while a new request waits
        sel = 1'b0;
        e.res = 8'd2; e.swp = 1'b0; e.err = 1'b0; e.code = 3'b000;
        sb.push_back(e);
        drive_accept(8'd1, 8'd1, 3'b000);
        tb_a = 8'd9; tb_b = 8'd9; tb_code = 3'b000;
        wait_rsp(1, "bp");
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid",  {31'b0, m_rsp_valid}, 32'd1);
            chk("bp_hold_result", {24'b0, m_rsp_result}, 32'd2);
            chk("bp_hold_ready",  {31'b0, m_req_ready}, 32'd0);
            @(negedge clk);
        end
        e = sb.pop_front();
        chk("bp_result", {24'b0, m_rsp_result}, {24'b0, e.res});
        chk("bp_code",   {29'b0, m_rsp_code},   {29'b0, e.code});
        e.res = 8'd18; e.swp = 1'b0; e.err = 1'b0; e.code = 3'b000;
        sb.push_back(e);
        tb_rsp_ready = 1'b1;
        chk("bp_handshake_ready", {31'b0, m_req_ready}, 32'd0);
        @(negedge clk);
        tb_rsp_ready = 1'b0;
        chk("bp_post_ready", {31'b0, m_req_ready}, 32'd1);
        chk("bp_post_valid", {31'b0, m_rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        v1 = 1'b0;
        wait_rsp(1, "bp_next");
        finish_rsp("bp_next");

        // Reset in the middle of a SETTLE_CYCLES = 4 op
        sel = 1'b1;
        drive_accept(8'd16, 8'd17, 3'b010);
        v4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_busy", {31'b0, m_busy}, 32'd1);
        rst4 = 1'b1;
        @(negedge clk);
        check_reset_state("rst_mid");
        chk("rst_mid_ready", {31'b0, m_req_ready}, 32'd0);
        @(negedge clk);
        rst4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_no_rsp", {31'b0, m_rsp_valid}, 32'd0);
        end
        run_op(1'b1, 8'd3, 8'd4, 3'b000, 8'd7, 1'b0, 1'b0, 4, "post_rst_add");

        // Mixed ops through the model, SETTLE_CYCLES = 1
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 3'($urandom_range(0, 7));
            if (i == 3) rb = 8'h00;
            e = exp_f(ra, rb, rc);
            run_op(1'b0, ra, rb, rc, e.res, e.swp, e.err, e.err ? 0 : 1, "mixed");
        end

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
